// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcodes,
// ALU operation codes and the bundle of datapath control signals.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_BZ   = 5'b00100;
  localparam logic [4:0] OP_J    = 5'b00101;
  localparam logic [4:0] OP_CALL = 5'b00110;
  localparam logic [4:0] OP_RET  = 5'b00111;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef struct packed {
    logic       ir_load;
    logic       pc_load;
    logic       sp_inc;
    logic       sp_dec;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       bAndZ;
    logic       jump;
    logic       addrOp;
    logic       aOp2;
    logic       writeDataOp;
    logic       pcOp;
    logic [3:0] aluOp;
  } ctrl_t;

  // Opcodes 00000..00111 are implemented; everything else except HALT faults.
  function automatic logic op_defined(input logic [4:0] op);
    return (op <= OP_RET);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, latched opcode) into datapath controls.
// Memory completion strobes are qualified by mem_ready in the access cycle.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [4:0] op_i,
  input  logic [3:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.addrOp   = 1'b1;
        ctrl_o.aOp2     = 1'b1;
      end
      S_DECODE: ctrl_o.ir_load = 1'b1;
      S_EXEC: begin
        case (op_i)
          OP_R:                 ctrl_o.aluOp = funct_i;
          OP_ADDI, OP_LD, OP_ST: begin
            ctrl_o.aluSrc = 1'b1;
            ctrl_o.aluOp  = ALU_ADD;
          end
          OP_BZ: begin
            ctrl_o.aluOp   = ALU_SUB;
            ctrl_o.bAndZ   = zero_i;
            ctrl_o.pc_load = 1'b1;
          end
          OP_J: begin
            ctrl_o.jump    = 1'b1;
            ctrl_o.pc_load = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        case (op_i)
          OP_LD: ctrl_o.mem_read = 1'b1;
          OP_ST: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.pc_load   = mem_ready_i;
          end
          // Stack accesses address through SP (addrOp=1, aOp2=0).
          OP_CALL: begin
            ctrl_o.mem_write   = 1'b1;
            ctrl_o.addrOp      = 1'b1;
            ctrl_o.writeDataOp = 1'b1;
            ctrl_o.jump        = mem_ready_i;
            ctrl_o.pc_load     = mem_ready_i;
            ctrl_o.sp_dec      = mem_ready_i;
          end
          OP_RET: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.addrOp   = 1'b1;
            ctrl_o.pcOp     = mem_ready_i;
            ctrl_o.pc_load  = mem_ready_i;
            ctrl_o.sp_inc   = mem_ready_i;
          end
          default: ;
        endcase
      end
      S_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_load   = 1'b1;
        case (op_i)
          OP_R: begin
            ctrl_o.regDst = 1'b1;
            ctrl_o.aluOp  = funct_i;
          end
          OP_ADDI: ctrl_o.aluSrc   = 1'b1;
          OP_LD:   ctrl_o.memToReg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: sequencing, memory wait watchdog and
// instruction latches; control decode lives in ctrl_decode.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_load,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       regDst,
  output logic       aluSrc,
  output logic       memToReg,
  output logic       bAndZ,
  output logic       jump,
  output logic       addrOp,
  output logic       aOp2,
  output logic       writeDataOp,
  output logic       pcOp,
  output logic [3:0] aluOp,
  output logic       halted,
  output logic       fault
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    op_q, op_d;
  logic [3:0]    funct_q, funct_d;
  logic          fault_q, fault_d;
  logic          started_q;
  ctrl_t         dec, ctrl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    funct_d = funct_q;
    fault_d = fault_q;
    // The first edge after reset release only arms the FSM; FETCH runs from then on.
    if (started_q) begin
      case (state_q)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            if (state_q == S_FETCH)  state_d = S_DECODE;
            else if (op_q == OP_LD)  state_d = S_WB;
            else                     state_d = S_FETCH;
          end else if (cnt_q == LIMIT_M1) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DECODE: begin
          op_d    = opcode;
          funct_d = funct;
          if (opcode == OP_HALT) begin
            state_d = S_HALT;
          end else if (!op_defined(opcode)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else if (opcode == OP_CALL || opcode == OP_RET) begin
            state_d = S_MEM;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R, OP_ADDI: state_d = S_WB;
            OP_LD, OP_ST:  state_d = S_MEM;
            default:       state_d = S_FETCH;
          endcase
        end
        S_WB:    state_d = S_FETCH;
        default: ;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      op_q      <= '0;
      funct_q   <= '0;
      fault_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      fault_q   <= fault_d;
      started_q <= 1'b1;
    end
  end

  ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .funct_i     (funct_q),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec)
  );

  // started_q is cleared asynchronously, so this also kills strobes during reset.
  assign ctrl = started_q ? dec : '0;

  assign ir_load     = ctrl.ir_load;
  assign pc_load     = ctrl.pc_load;
  assign sp_inc      = ctrl.sp_inc;
  assign sp_dec      = ctrl.sp_dec;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign reg_write   = ctrl.reg_write;
  assign regDst      = ctrl.regDst;
  assign aluSrc      = ctrl.aluSrc;
  assign memToReg    = ctrl.memToReg;
  assign bAndZ       = ctrl.bAndZ;
  assign jump        = ctrl.jump;
  assign addrOp      = ctrl.addrOp;
  assign aOp2        = ctrl.aOp2;
  assign writeDataOp = ctrl.writeDataOp;
  assign pcOp        = ctrl.pcOp;
  assign aluOp       = ctrl.aluOp;
  assign halted      = started_q && (state_q == S_HALT);
  assign fault       = fault_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: per-instruction phase timelines drive a reference
// model of the expected control outputs, cycle by cycle.
module tb_cpu_ctrl_fsm;

  localparam int WL  = 15;
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opcode = '0;
  logic [3:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic ir_load, pc_load, sp_inc, sp_dec, mem_read, mem_write, reg_write;
  logic regDst, aluSrc, memToReg, bAndZ, jump, addrOp, aOp2, writeDataOp, pcOp;
  logic [3:0] aluOp;
  logic halted, fault;
  logic [21:0] dut_v;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ph;
    bit rdy;
  } cyc_t;

  cpu_ctrl_fsm #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_load(pc_load), .sp_inc(sp_inc),
    .sp_dec(sp_dec), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .regDst(regDst), .aluSrc(aluSrc), .memToReg(memToReg), .bAndZ(bAndZ), .jump(jump),
    .addrOp(addrOp), .aOp2(aOp2), .writeDataOp(writeDataOp), .pcOp(pcOp),
    .aluOp(aluOp), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign dut_v = {ir_load, pc_load, sp_inc, sp_dec, mem_read, mem_write, reg_write,
                  regDst, aluSrc, memToReg, bAndZ, jump, addrOp, aOp2, writeDataOp,
                  pcOp, aluOp, halted, fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for one cycle, straight from the instruction set table.
  function automatic logic [21:0] exp_out(input int ph, input logic [4:0] op,
                                          input logic [3:0] fn, input logic z,
                                          input bit rdy, input bit flt);
    logic ir, pcl, spi, spd, mr, mw, rw, rd, as, m2r, bz, jp, ao, a2, wdo, pco, hl;
    logic [3:0] alu;
    {ir, pcl, spi, spd, mr, mw, rw, rd, as, m2r, bz, jp, ao, a2, wdo, pco, hl} = '0;
    alu = 4'b0000;
    case (ph)
      P_F: begin mr = 1; ao = 1; a2 = 1; end
      P_D: ir = 1;
      P_E: begin
        case (op)
          5'b00000: alu = fn;
          5'b00001, 5'b00010, 5'b00011: as = 1;
          5'b00100: begin alu = 4'b0001; bz = z; pcl = 1; end
          5'b00101: begin jp = 1; pcl = 1; end
          default: ;
        endcase
      end
      P_M: begin
        case (op)
          5'b00010: mr = 1;
          5'b00011: begin mw = 1; pcl = rdy; end
          5'b00110: begin mw = 1; ao = 1; wdo = 1; jp = rdy; pcl = rdy; spd = rdy; end
          5'b00111: begin mr = 1; ao = 1; pco = rdy; pcl = rdy; spi = rdy; end
          default: ;
        endcase
      end
      P_W: begin
        rw = 1;
        pcl = 1;
        case (op)
          5'b00000: begin rd = 1; alu = fn; end
          5'b00001: as = 1;
          5'b00010: m2r = 1;
          default: ;
        endcase
      end
      P_H: hl = 1;
      default: ;
    endcase
    return {ir, pcl, spi, spd, mr, mw, rw, rd, as, m2r, bz, jp, ao, a2, wdo, pco,
            alu, hl, flt};
  endfunction

  // Called just after a negedge sample; leaves rst_n high before the next posedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(dut_v), 32'd0);
    @(posedge clk);
    #1 chk("rst_hold", 32'(dut_v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_gap", 32'(dut_v), 32'd0);
  endtask

  // zmode: 0/1 force zero, 2 random. abort_at: cycle index at which reset is pulsed.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] fn, input int zmode,
                           input int wf, input int wm, input int abort_at);
    cyc_t q[$];
    bit   hfault = 0;
    bit   ended_halt = 0;
    bit   is_mem;
    int   pcl = 0;
    logic z;
    is_mem = (op == 5'b00010 || op == 5'b00011 || op == 5'b00110 || op == 5'b00111);
    if (wf >= WL) begin
      repeat (WL) q.push_back('{P_F, 1'b0});
      hfault = 1;
      ended_halt = 1;
    end else begin
      repeat (wf) q.push_back('{P_F, 1'b0});
      q.push_back('{P_F, 1'b1});
      q.push_back('{P_D, 1'b0});
      if (op == 5'b11111) begin
        ended_halt = 1;
      end else if (op > 5'b00111) begin
        ended_halt = 1;
        hfault = 1;
      end else begin
        if (op != 5'b00110 && op != 5'b00111) q.push_back('{P_E, 1'b0});
        if (is_mem) begin
          if (wm >= WL) begin
            repeat (WL) q.push_back('{P_M, 1'b0});
            hfault = 1;
            ended_halt = 1;
          end else begin
            repeat (wm) q.push_back('{P_M, 1'b0});
            q.push_back('{P_M, 1'b1});
          end
        end
        if (!ended_halt && (op == 5'b00000 || op == 5'b00001 || op == 5'b00010))
          q.push_back('{P_W, 1'b0});
      end
    end
    if (ended_halt) repeat (3) q.push_back('{P_H, 1'b0});

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      mem_ready = (q[i].ph == P_F || q[i].ph == P_M) ? q[i].rdy : 1'($urandom);
      opcode    = (q[i].ph == P_D) ? op : 5'($urandom);
      funct     = (q[i].ph == P_D) ? fn : 4'($urandom);
      z         = (zmode == 2) ? 1'($urandom) : zmode[0];
      zero      = z;
      @(negedge clk);
      chk($sformatf("op%02h_cyc%0d", op, i), 32'(dut_v),
          32'(exp_out(q[i].ph, op, fn, z, q[i].rdy, hfault && q[i].ph == P_H)));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      if (pc_load) pcl++;
      if (i == abort_at) begin
        do_reset();
        return;
      end
    end
    chk($sformatf("pc_load_count_op%02h", op), 32'(pcl), ended_halt ? 32'd0 : 32'd1);
    if (ended_halt) do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rop;
    int         r, rwm;
    #1 chk("reset_state", 32'(dut_v), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset_gap", 32'(dut_v), 32'd0);

    run_instr(5'b00000, 4'b0010, 2, 0, 0, -1);   // R-type, zero wait
    run_instr(5'b00010, 4'b0111, 2, 0, 3, -1);   // LD, 3 wait cycles in MEM
    run_instr(5'b00100, 4'b0000, 1, 1, 0, -1);   // BZ taken
    run_instr(5'b00100, 4'b0000, 0, 0, 0, -1);   // BZ not taken
    run_instr(5'b00110, 4'b0000, 2, 0, 2, -1);   // CALL
    run_instr(5'b00111, 4'b0000, 2, 2, 1, -1);   // RET
    run_instr(5'b00001, 4'b1010, 2, 2, 0, -1);   // ADDI
    run_instr(5'b00011, 4'b0000, 2, 0, 0, -1);   // ST
    run_instr(5'b00101, 4'b0000, 2, 0, 0, -1);   // J
    run_instr(5'b00000, 4'b1111, 2, WL - 1, 0, -1); // longest legal fetch wait
    run_instr(5'b00000, 4'b0000, 2, WL, 0, -1);  // fetch timeout
    run_instr(5'b10101, 4'b0000, 2, 0, 0, -1);   // undefined opcode
    run_instr(5'b11111, 4'b0000, 2, 0, 0, -1);   // HALT
    run_instr(5'b00011, 4'b0000, 2, 0, 10, 5);   // reset during ST wait
    run_instr(5'b00000, 4'b0101, 2, 0, 0, -1);   // restart after abort
    run_instr(5'b00010, 4'b0000, 2, 1, WL, -1);  // MEM timeout

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16)       rop = 5'(r % 8);
      else if (r == 16) rop = 5'b11111;
      else if (r == 17) rop = 5'($urandom_range(8, 30));
      else              rop = 5'($urandom_range(0, 7));
      rwm = ($urandom_range(0, 19) == 0) ? WL : $urandom_range(0, 4);
      run_instr(rop, 4'($urandom), 2, $urandom_range(0, 3), rwm, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
